sync_width_conv_fifo: RTL and testbench

SYNC_WIDTH_CONV_FIFO -- requirements
Module: sync_width_conv_fifo

---
 rtl/sync_width_conv_fifo.sv | 117 +++++++++++
 tb/tb_sync_width_conv_fifo.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sync_width_conv_fifo.sv
// Single-clock FIFO that accepts DATAIN_WIDTH-bit words and returns DATAOUT_WIDTH-bit
// words, storing data internally as UNIT-sized slices (UNIT = narrower of the two widths).
module sync_width_conv_fifo #(
  parameter int DATAIN_WIDTH  = 8,
  parameter int DATAOUT_WIDTH = 16,
  parameter int DEPTH_UNITS   = 32,
  parameter int AF_THRESH     = 28,
  parameter int AE_THRESH     = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           w_en,
  input  logic [DATAIN_WIDTH-1:0]        data_write,
  input  logic                           r_en,
  output logic [DATAOUT_WIDTH-1:0]       data_read,
  output logic                           flag_full,
  output logic                           flag_empty,
  output logic                           flag_almost_full,
  output logic                           flag_almost_empty,
  output logic [$clog2(DEPTH_UNITS):0]   level,
  output logic                           overflow,
  output logic                           underflow
);

  localparam int UNIT = (DATAIN_WIDTH < DATAOUT_WIDTH) ? DATAIN_WIDTH : DATAOUT_WIDTH;
  localparam int WR   = DATAIN_WIDTH / UNIT;
  localparam int RR   = DATAOUT_WIDTH / UNIT;
  localparam int PW   = $clog2(DEPTH_UNITS);
  localparam int LW   = PW + 1;

  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH_UNITS);
  localparam logic [LW-1:0] WR_L    = LW'(WR);
  localparam logic [LW-1:0] RR_L    = LW'(RR);
  localparam logic [LW-1:0] AF_L    = LW'(AF_THRESH);
  localparam logic [LW-1:0] AE_L    = LW'(AE_THRESH);
  localparam logic [PW-1:0] WR_P    = PW'(WR);
  localparam logic [PW-1:0] RR_P    = PW'(RR);

  // Handshake: a write is taken on any rising edge where w_en=1 and WR units are free;
  // a read is taken where r_en=1 and RR units are stored. Requests that cannot be
  // taken are dropped and flagged by a one-cycle overflow/underflow pulse.

  logic [UNIT-1:0]          mem_q [DEPTH_UNITS];
  logic [PW-1:0]            wptr_q, wptr_d;
  logic [PW-1:0]            rptr_q, rptr_d;
  logic [LW-1:0]            level_q, level_d;
  logic [DATAOUT_WIDTH-1:0] data_read_q, data_read_d;
  logic                     overflow_q, overflow_d;
  logic                     underflow_q, underflow_d;
  logic [DATAOUT_WIDTH-1:0] rd_word;
  logic                     full, empty, wacc, racc;

  assign full  = (DEPTH_L - level_q) < WR_L;
  assign empty = level_q < RR_L;
  // Acceptance looks only at the pre-edge level, so a read never sees same-cycle writes.
  assign wacc  = rst && w_en && !full;
  assign racc  = rst && r_en && !empty;

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < RR; i++) begin
      rd_word[i*UNIT +: UNIT] = mem_q[rptr_q + PW'(i)];
    end
  end

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    level_d     = level_q;
    data_read_d = data_read_q;
    overflow_d  = w_en && full;
    underflow_d = r_en && empty;
    if (wacc) wptr_d = wptr_q + WR_P;
    if (racc) begin
      rptr_d      = rptr_q + RR_P;
      data_read_d = rd_word;
    end
    level_d = level_q + (wacc ? WR_L : '0) - (racc ? RR_L : '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      data_read_q <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      data_read_q <= data_read_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset; the pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (wacc) begin
      for (int i = 0; i < WR; i++) begin
        mem_q[wptr_q + PW'(i)] <= data_write[i*UNIT +: UNIT];
      end
    end
  end

  assign data_read         = data_read_q;
  assign level             = level_q;
  assign overflow          = overflow_q;
  assign underflow         = underflow_q;
  assign flag_full         = full;
  assign flag_empty        = empty;
  assign flag_almost_full  = level_q >= AF_L;
  assign flag_almost_empty = level_q <= AE_L;

endmodule

// File: tb/tb_sync_width_conv_fifo.sv
// Bench for sync_width_conv_fifo at default parameters (8-bit in, 16-bit out, 32 units):
// a constant vector table, a fill-to-full sequence and a random run against a queue model.
module tb_sync_width_conv_fifo;

  localparam int DEPTH = 32;

  logic        clk;
  logic        rst;
  logic        w_en;
  logic        r_en;
  logic [7:0]  data_write;
  logic [15:0] data_read;
  logic        flag_full, flag_empty, flag_almost_full, flag_almost_empty;
  logic [5:0]  level;
  logic        overflow, underflow;

  int n_tests;
  int n_fail;

  logic [7:0]  exp_q[$];
  logic [15:0] exp_dr;
  logic        exp_ovf, exp_udf;

  typedef struct {
    logic        rst_n;
    logic        w;
    logic        r;
    logic [7:0]  d;
    logic [5:0]  lvl;
    logic        full;
    logic        empty;
    logic        af;
    logic        ae;
    logic        ovf;
    logic        udf;
    logic [15:0] dr;
  } vec_t;

  vec_t vecs[13];

  sync_width_conv_fifo dut (
    .clk               (clk),
    .rst               (rst),
    .w_en              (w_en),
    .data_write        (data_write),
    .r_en              (r_en),
    .data_read         (data_read),
    .flag_full         (flag_full),
    .flag_empty        (flag_empty),
    .flag_almost_full  (flag_almost_full),
    .flag_almost_empty (flag_almost_empty),
    .level             (level),
    .overflow          (overflow),
    .underflow         (underflow)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst_v, input logic w, input logic r, input logic [7:0] d);
    @(negedge clk);
    rst        = rst_v;
    w_en       = w;
    r_en       = r;
    data_write = d;
    @(posedge clk);
    #1;
  endtask

  // One clock through the scoreboard: decide acceptance from the pre-edge model level,
  // update the model, then compare every output.
  task automatic cyc(input logic rst_v, input logic w, input logic r, input logic [7:0] d);
    int   lvl;
    logic wacc, racc;
    logic [7:0] lo, hi;
    lvl = exp_q.size();
    drive(rst_v, w, r, d);
    if (!rst_v) begin
      exp_q.delete();
      exp_dr  = 16'h0;
      exp_ovf = 1'b0;
      exp_udf = 1'b0;
    end else begin
      racc    = r && (lvl >= 2);
      wacc    = w && ((DEPTH - lvl) >= 1);
      exp_ovf = w && !wacc;
      exp_udf = r && !racc;
      if (racc) begin
        lo     = exp_q.pop_front();
        hi     = exp_q.pop_front();
        exp_dr = {hi, lo};
      end
      if (wacc) exp_q.push_back(d);
    end
    chk("level",     32'(level),             32'(exp_q.size()));
    chk("data_read", 32'(data_read),         32'(exp_dr));
    chk("full",      32'(flag_full),         32'((DEPTH - exp_q.size()) < 1));
    chk("empty",     32'(flag_empty),        32'(exp_q.size() < 2));
    chk("a_full",    32'(flag_almost_full),  32'(exp_q.size() >= 28));
    chk("a_empty",   32'(flag_almost_empty), 32'(exp_q.size() <= 4));
    chk("overflow",  32'(overflow),          32'(exp_ovf));
    chk("underflow", 32'(underflow),         32'(exp_udf));
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b0;
    w_en       = 1'b0;
    r_en       = 1'b0;
    data_write = 8'h00;
    exp_dr     = 16'h0;
    exp_ovf    = 1'b0;
    exp_udf    = 1'b0;

    //            rst   w     r     d      lvl    full  empty af    ae    ovf   udf   dr
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 8'h55, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 8'h55, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 8'h11, 6'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 8'h22, 6'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 8'h00, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h2211};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 8'hAA, 6'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h2211};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 8'h00, 6'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h2211};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'h00, 6'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h2211};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 8'hBB, 6'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h2211};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 8'hCC, 6'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'hBBAA};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 8'hDD, 6'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'hBBAA};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 8'h00, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'hDDCC};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 8'h00, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'hDDCC};

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].rst_n, vecs[i].w, vecs[i].r, vecs[i].d);
      chk($sformatf("vec%0d_level", i),   32'(level),             32'(vecs[i].lvl));
      chk($sformatf("vec%0d_full", i),    32'(flag_full),         32'(vecs[i].full));
      chk($sformatf("vec%0d_empty", i),   32'(flag_empty),        32'(vecs[i].empty));
      chk($sformatf("vec%0d_a_full", i),  32'(flag_almost_full),  32'(vecs[i].af));
      chk($sformatf("vec%0d_a_empty", i), 32'(flag_almost_empty), 32'(vecs[i].ae));
      chk($sformatf("vec%0d_ovf", i),     32'(overflow),          32'(vecs[i].ovf));
      chk($sformatf("vec%0d_udf", i),     32'(underflow),         32'(vecs[i].udf));
      chk($sformatf("vec%0d_dr", i),      32'(data_read),         32'(vecs[i].dr));
    end

    // Fill to full, watch almost-full rise at 28, then push one more for overflow.
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 8'(i * 7 + 3));
      chk("fill_af", 32'(flag_almost_full), 32'((i + 1) >= 28));
    end
    chk("fill_full",  32'(flag_full), 32'd1);
    chk("fill_level", 32'(level),     32'd32);
    cyc(1'b1, 1'b1, 1'b0, 8'hEE);
    chk("ovf_pulse", 32'(overflow), 32'd1);
    chk("ovf_level", 32'(level),    32'd32);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    chk("ovf_clear", 32'(overflow), 32'd0);
    for (int i = 0; i < DEPTH / 2; i++) cyc(1'b1, 1'b0, 1'b1, 8'h00);
    cyc(1'b1, 1'b0, 1'b1, 8'h00);
    chk("drain_udf", 32'(underflow), 32'd1);

    // Random traffic across pointer wrap with a reset pulse in the middle.
    for (int i = 0; i < 200; i++) begin
      if (i == 100) begin
        cyc(1'b0, 1'b1, 1'b1, 8'($urandom_range(0, 255)));
      end else begin
        cyc(1'b1, ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 45),
            8'($urandom_range(0, 255)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
